ntt_butterfly: RTL and testbench
================================

# ntt_butterfly

Sequential radix-2 butterfly controller for the Dilithium NTT/INTT datapath (q = 8380417). It sits directly upstream of fqmul_32bit, driving its start/a/b inputs and consuming its done/reduce outputs. It computes either a forward Cooley-Tukey butterfly or an inverse Gentleman-Sande butterfly on signed 32-bit coefficients. A start/done handshake connects it to the NTT address sequencer.

## Interface
- Parameters
- WIDTH, 32: coefficient and twiddle width (signed, two's complement).
- Ports
- clock  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = forward CT, 1 = inverse GS; latched on start.
- in_a  in  WIDTH  signed coefficient a[j]; latched on start.
- in_b  in  WIDTH  signed coefficient a[j+len]; latched on start.
- zeta  in  WIDTH  signed Montgomery-domain twiddle; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; out_a/out_b valid.
- out_a  out  WIDTH  signed result for a[j].
- out_b  out  WIDTH  signed result for a[j+len].
- mul_start  out  1  one-cycle start pulse to fqmul_32bit.
- mul_a  out  WIDTH  multiplier operand a (always the latched zeta).
- mul_b  out  WIDTH  multiplier operand b.
- mul_done  in  1  multiplier completion.
- mul_reduce  in  WIDTH  signed Montgomery product zeta*x*2^-32 mod q.

## Operation
- States: IDLE, PRE, MREQ, MWAIT, FIN.
- IDLE: when start=1, latch mode/in_a/in_b/zeta into ra/rb/rz. If mode=0, go to MREQ. If mode=1, go to PRE.
- PRE (GS only): sum <= ra + rb, diff <= ra - rb. Then go to MREQ.
- MREQ: mul_start=1 for exactly this cycle, with mul_a=rz. mul_b=rb (CT) or diff (GS). Go to MWAIT. A mul_done seen in MREQ is ignored.
- MWAIT: mul_a/mul_b held stable. Stay until mul_done=1, then capture t <= mul_reduce and go to FIN.
- FIN: done=1.
  - CT: out_a <= ra + t, out_b <= ra - t.
  - GS: out_a <= sum, out_b <= t.
  - Next state is IDLE.
- Arithmetic: all add/sub is WIDTH-bit two's-complement wrap-around (C int32 semantics). There is no modular correction, because reduction is the sequencer's responsibility.
- out_a/out_b are registered. They update only at the FIN edge and hold until the next FIN.
- start while busy=1 is ignored. The operation is not queued.
- mul_done outside MWAIT is ignored.
- Reset (asynchronous, any state) sets state=IDLE and clears busy, done, mul_start, mul_a, mul_b, out_a, out_b and all internal registers to 0. An in-flight multiplier result is discarded. After reset, a new operation may start on the first cycle reset is deasserted.

## Timing
- E0 is the edge that samples start. L (L >= 1) is the number of cycles from the edge sampling mul_start to the edge sampling mul_done.
- CT: MREQ occupies the cycle after E0, MWAIT lasts L cycles, and done is high in cycle L+2 after E0. Start-to-done latency is L+2 cycles.
- GS: one extra PRE cycle, so latency is L+3 cycles.
- busy rises the cycle after E0 and falls the cycle after done.
- Back-to-back operation: start asserted during the done cycle is ignored, because the FSM is not yet in IDLE. The earliest accepted restart is the first cycle after done. Minimum issue interval is L+3 cycles (CT) and L+4 cycles (GS).
- Reset values: busy=0, done=0, mul_start=0, mul_a=0, mul_b=0, out_a=0, out_b=0.

## Test plan
- The bench uses an fqmul stub with programmable latency L and a programmable return value, plus one run against the real fqmul_32bit.
- CT, stub returns 100, L=3, in_a=1000, in_b=5 → out_a=1100, out_b=900; done exactly 5 cycles after E0; mul_b=5 during the request; mul_start high exactly 1 cycle.
- GS, stub returns -7, L=1, in_a=10, in_b=3 → mul_b=7; out_a=13, out_b=-7; done 4 cycles after E0.
- Wrap-around: CT, in_a=32'h7FFFFFFF, stub returns 1 → out_a=32'h80000000, out_b=32'h7FFFFFFE.
- Real fqmul_32bit, CT, zeta=0, in_a=121212, in_b=-218182981 → out_a=out_b=121212. Repeat with zeta=1, in_b=1: out_a/out_b equal in_a ± the bench's Montgomery reference of 1*1.
- Protocol: start re-pulsed during MWAIT and during the done cycle → ignored, only one done. A spurious mul_done in MREQ → ignored; the result is taken from the later done.
- Reset: assert reset low in MWAIT → busy, done, outputs and mul_start are 0 immediately (asynchronous). A subsequent mul_done produces no done. A fresh CT op after release completes normally.

Source files
------------

// File: rtl/ntt_butterfly_if.sv
`default_nettype none
// ============================================================================
// Module      : ntt_butterfly_if
// Description : Bundles the sequencer handshake and the fqmul_32bit request
//               channel of the NTT butterfly controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ntt_butterfly_if #(
  parameter int WIDTH = 32
);
  // Sequencer side
  logic                    start;
  logic                    mode;
  logic signed [WIDTH-1:0] in_a;
  logic signed [WIDTH-1:0] in_b;
  logic signed [WIDTH-1:0] zeta;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] out_a;
  logic signed [WIDTH-1:0] out_b;
  // Multiplier side
  logic                    mul_start;
  logic signed [WIDTH-1:0] mul_a;
  logic signed [WIDTH-1:0] mul_b;
  logic                    mul_done;
  logic signed [WIDTH-1:0] mul_reduce;

  // The butterfly itself
  modport slave (
    input  start, mode, in_a, in_b, zeta, mul_done, mul_reduce,
    output busy, done, out_a, out_b, mul_start, mul_a, mul_b
  );

  // The environment: address sequencer plus multiplier
  modport master (
    output start, mode, in_a, in_b, zeta, mul_done, mul_reduce,
    input  busy, done, out_a, out_b, mul_start, mul_a, mul_b
  );
endinterface
`default_nettype wire

// File: rtl/ntt_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : ntt_butterfly
// Description : Sequential radix-2 butterfly controller (Dilithium, q=8380417).
//               Forward Cooley-Tukey (mode=0) or inverse Gentleman-Sande
//               (mode=1) on signed WIDTH-bit coefficients, using an external
//               Montgomery multiplier through a start/done request channel.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_butterfly #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  ntt_butterfly_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    MREQ  = 3'd2,
    MWAIT = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t                  state;
  logic                    rmode;
  logic signed [WIDTH-1:0] ra;
  logic signed [WIDTH-1:0] rb;
  logic signed [WIDTH-1:0] sum;

  // Control FSM with registered outputs. mul_a doubles as the latched
  // twiddle and mul_b as the GS difference register, so both are already
  // stable when MREQ raises mul_start. The results are formed on the edge
  // entering FIN so that out_a/out_b are valid together with done; all
  // add/sub wraps at WIDTH bits with no modular correction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rmode         <= 1'b0;
      ra            <= '0;
      rb            <= '0;
      sum           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.out_a     <= '0;
      bus.out_b     <= '0;
      bus.mul_start <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
    end else begin
      bus.mul_start <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rmode     <= bus.mode;
            ra        <= bus.in_a;
            rb        <= bus.in_b;
            bus.mul_a <= bus.zeta;
            bus.mul_b <= bus.in_b;
            bus.busy  <= 1'b1;
            if (bus.mode) begin
              state <= PRE;
            end else begin
              state         <= MREQ;
              bus.mul_start <= 1'b1;
            end
          end
        end
        PRE: begin
          sum           <= ra + rb;
          bus.mul_b     <= ra - rb;
          bus.mul_start <= 1'b1;
          state         <= MREQ;
        end
        MREQ: begin
          // A mul_done arriving here belongs to nothing we issued.
          state <= MWAIT;
        end
        MWAIT: begin
          if (bus.mul_done) begin
            bus.done <= 1'b1;
            state    <= FIN;
            if (rmode) begin
              bus.out_a <= sum;
              bus.out_b <= bus.mul_reduce;
            end else begin
              bus.out_a <= ra + bus.mul_reduce;
              bus.out_b <= ra - bus.mul_reduce;
            end
          end
        end
        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_butterfly
// Description : Directed, table-driven bench for ntt_butterfly with a
//               behavioural fqmul stub (programmable latency and result).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_butterfly;

  localparam int WIDTH = 32;
  localparam longint Q    = 8380417;
  localparam longint QINV = 58728449;

  logic clock;
  logic reset;

  ntt_butterfly_if #(.WIDTH(WIDTH)) ifc ();

  ntt_butterfly #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Stub multiplier controls
  logic        stub_en  = 1'b1;
  int          stub_lat = 1;
  logic [31:0] stub_ret = '0;

  // Reference Montgomery reduction (C int32 semantics, q = 8380417)
  function automatic logic [31:0] mont(input longint a);
    int     t;
    longint r;
    t = int'(a * QINV);
    r = (a - longint'(t) * Q) >>> 32;
    return r[31:0];
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // fqmul stub: answers a sampled mul_start exactly stub_lat edges later
  always @(posedge clock) begin
    if (stub_en && reset && ifc.mul_start === 1'b1) begin
      for (int i = 1; i < stub_lat; i++) @(posedge clock);
      #1;
      ifc.mul_done   = 1'b1;
      ifc.mul_reduce = stub_ret;
      @(posedge clock);
      #1 ifc.mul_done = 1'b0;
    end
  end

  // One full operation; called at #1 after an edge
  task automatic run_op(input logic md, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z, input int l, input logic [31:0] ret,
                        output logic [31:0] oa, output logic [31:0] ob,
                        output logic [31:0] ma, output logic [31:0] mb,
                        output int lat, output int ms_cnt,
                        output logic busy1, output logic done_after,
                        output logic busy_after);
    int edges;
    stub_lat  = l;
    stub_ret  = ret;
    ifc.mode  = md;
    ifc.in_a  = a;
    ifc.in_b  = b;
    ifc.zeta  = z;
    ifc.start = 1'b1;
    @(posedge clock);
    #1 ifc.start = 1'b0;
    busy1  = ifc.busy;
    edges  = 0;
    ms_cnt = 0;
    ma     = '0;
    mb     = '0;
    while (ifc.done !== 1'b1 && edges < 50) begin
      if (ifc.mul_start === 1'b1) begin
        ms_cnt++;
        ma = ifc.mul_a;
        mb = ifc.mul_b;
      end
      @(posedge clock);
      #1 edges++;
    end
    lat = edges + 1;
    oa  = ifc.out_a;
    ob  = ifc.out_b;
    @(posedge clock);
    #1;
    done_after = ifc.done;
    busy_after = ifc.busy;
  endtask

  typedef struct {
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          l;
    logic [31:0] ret;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_mb;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] oa, ob, ma, mb, mref;
    int          lat, msc, dones, starts;
    logic        b1, da, ba;

    mref = mont(64'sd1);
    //           mode  a               b                 zeta    L  ret          out_a          out_b         mul_b          lat
    vecs[0] = '{1'b0, 32'd1000,       32'd5,            32'd17, 3, 32'd100,     32'd1100,      32'd900,      32'd5,         5};
    vecs[1] = '{1'b1, 32'd10,         32'd3,            32'd23, 1, -32'sd7,     32'd13,        -32'sd7,      32'd7,         4};
    vecs[2] = '{1'b0, 32'h7FFFFFFF,   32'd2,            32'd5,  2, 32'd1,       32'h80000000,  32'h7FFFFFFE, 32'd2,         4};
    vecs[3] = '{1'b0, 32'd121212,     -32'sd218182981,  32'd0,  4, mont(64'sd0), 32'd121212,   32'd121212,   -32'sd218182981, 6};
    vecs[4] = '{1'b0, 32'd121212,     32'd1,            32'd1,  2, mref,        32'd121212 + mref, 32'd121212 - mref, 32'd1, 4};
    vecs[5] = '{1'b1, 32'h80000000,   32'd1,            32'd9,  2, 32'd5,       32'h80000001,  32'd5,        32'h7FFFFFFF,  5};

    reset          = 1'b0;
    ifc.start      = 1'b0;
    ifc.mode       = 1'b0;
    ifc.in_a       = '0;
    ifc.in_b       = '0;
    ifc.zeta       = '0;
    ifc.mul_done   = 1'b0;
    ifc.mul_reduce = '0;

    // Reset state
    #12;
    check("rst_busy", 0, {31'd0, ifc.busy}, 32'd0);
    check("rst_done", 0, {31'd0, ifc.done}, 32'd0);
    check("rst_mstart", 0, {31'd0, ifc.mul_start}, 32'd0);
    check("rst_mula", 0, ifc.mul_a, 32'd0);
    check("rst_mulb", 0, ifc.mul_b, 32'd0);
    check("rst_outa", 0, ifc.out_a, 32'd0);
    check("rst_outb", 0, ifc.out_b, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].l, vecs[i].ret,
             oa, ob, ma, mb, lat, msc, b1, da, ba);
      check("out_a", i, oa, vecs[i].exp_a);
      check("out_b", i, ob, vecs[i].exp_b);
      check("mul_a", i, ma, vecs[i].z);
      check("mul_b", i, mb, vecs[i].exp_mb);
      check("latency", i, lat, vecs[i].exp_lat);
      check("mstart_cycles", i, msc, 32'd1);
      check("busy_rise", i, {31'd0, b1}, 32'd1);
      check("done_pulse", i, {31'd0, da}, 32'd0);
      check("busy_fall", i, {31'd0, ba}, 32'd0);
    end

    // Start re-pulsed in MWAIT and in the done cycle: single operation only
    stub_lat  = 3;
    stub_ret  = 32'd10;
    ifc.mode  = 1'b0;
    ifc.in_a  = 32'd200;
    ifc.in_b  = 32'd1;
    ifc.zeta  = 32'd4;
    ifc.start = 1'b1;
    @(posedge clock);
    #1 ifc.start = 1'b0;
    dones  = 0;
    starts = 0;
    oa     = '0;
    ob     = '0;
    for (int i = 0; i < 14; i++) begin
      if (ifc.mul_start === 1'b1) starts++;
      if (ifc.done === 1'b1) begin
        dones++;
        oa = ifc.out_a;
        ob = ifc.out_b;
      end
      if (i == 1 || ifc.done === 1'b1) ifc.start = 1'b1;
      @(posedge clock);
      #1 ifc.start = 1'b0;
    end
    check("repulse_dones", 0, dones, 32'd1);
    check("repulse_mstarts", 0, starts, 32'd1);
    check("repulse_out_a", 0, oa, 32'd210);
    check("repulse_out_b", 0, ob, 32'd190);

    // Spurious mul_done during MREQ is ignored
    stub_en   = 1'b0;
    ifc.mode  = 1'b0;
    ifc.in_a  = 32'd500;
    ifc.in_b  = 32'd4;
    ifc.zeta  = 32'd11;
    ifc.start = 1'b1;
    @(posedge clock);
    #1 ifc.start = 1'b0;
    check("spur_in_mreq", 0, {31'd0, ifc.mul_start}, 32'd1);
    ifc.mul_done   = 1'b1;
    ifc.mul_reduce = 32'd999;
    @(posedge clock);
    #1 ifc.mul_done = 1'b0;
    @(posedge clock);
    #1;
    check("spur_no_done", 0, {31'd0, ifc.done}, 32'd0);
    ifc.mul_done   = 1'b1;
    ifc.mul_reduce = 32'd50;
    @(posedge clock);
    #1 ifc.mul_done = 1'b0;
    check("spur_done", 0, {31'd0, ifc.done}, 32'd1);
    check("spur_out_a", 0, ifc.out_a, 32'd550);
    check("spur_out_b", 0, ifc.out_b, 32'd450);
    @(posedge clock);
    #1;

    // Asynchronous reset in MWAIT
    ifc.mode  = 1'b0;
    ifc.in_a  = 32'd77;
    ifc.in_b  = 32'd3;
    ifc.zeta  = 32'd9;
    ifc.start = 1'b1;
    @(posedge clock);
    #1 ifc.start = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 1, {31'd0, ifc.busy}, 32'd0);
    check("arst_done", 1, {31'd0, ifc.done}, 32'd0);
    check("arst_mstart", 1, {31'd0, ifc.mul_start}, 32'd0);
    check("arst_mula", 1, ifc.mul_a, 32'd0);
    check("arst_mulb", 1, ifc.mul_b, 32'd0);
    check("arst_outa", 1, ifc.out_a, 32'd0);
    check("arst_outb", 1, ifc.out_b, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    ifc.mul_done   = 1'b1;
    ifc.mul_reduce = 32'd5;
    @(posedge clock);
    #1 ifc.mul_done = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (ifc.done === 1'b1 || ifc.busy === 1'b1) dones++;
      @(posedge clock);
      #1;
    end
    check("arst_no_done", 1, dones, 32'd0);

    stub_en = 1'b1;
    run_op(1'b0, 32'd40, 32'd2, 32'd3, 2, 32'd6, oa, ob, ma, mb, lat, msc, b1, da, ba);
    check("post_rst_out_a", 1, oa, 32'd46);
    check("post_rst_out_b", 1, ob, 32'd34);
    check("post_rst_latency", 1, lat, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
